// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter that shares one synchronous RAM between NUM_PORTS requestors.
// Port 0 is the program loader; boot_mode restricts grants to it until loading is done.
module unified_mem_arbiter #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned NUM_PORTS    = 2,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            boot_mode,
  input  logic [NUM_PORTS-1:0]            req,
  input  logic [NUM_PORTS-1:0]            we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata,
  output logic [NUM_PORTS-1:0]            gnt,
  output logic [NUM_PORTS-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic                            mem_we,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  output logic                            busy
);

  localparam int unsigned PW = $clog2(NUM_PORTS);
  localparam int unsigned CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StGrant, StRdWait} state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         rr_q, rr_d;
  logic [PW-1:0]         owner_q, owner_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]  gnt_q, gnt_d;
  logic [NUM_PORTS-1:0]  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  busy_q, busy_d;

  logic [NUM_PORTS-1:0]  eligible;
  logic                  found;
  logic [PW-1:0]         win;
  logic [PW:0]           idx;
  logic [PW:0]           rr_inc;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  rd_done;

  // Cyclic search starting at rr_q; idx stays below 2*NUM_PORTS so one wrap suffices.
  always_comb begin
    eligible = boot_mode ? {{(NUM_PORTS-1){1'b0}}, req[0]} : req;
    found    = 1'b0;
    win      = '0;
    idx      = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      idx = {1'b0, rr_q} + (PW+1)'(i);
      if (idx >= (PW+1)'(NUM_PORTS)) idx = idx - (PW+1)'(NUM_PORTS);
      if (!found && eligible[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (win == PW'(p)) begin
        sel_we    = we[p];
        sel_addr  = addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = wdata[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign rr_inc = {1'b0, win} + (PW+1)'(1);

  // The read counter covers the GRANT cycle too, so rvalid lands READ_LATENCY cycles after gnt.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    rvalid_d    = '0;
    rdata_d     = rdata_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          gnt_d       = NUM_PORTS'(1) << win;
          mem_we_d    = sel_we;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          owner_d     = win;
          rr_d        = (rr_inc == (PW+1)'(NUM_PORTS)) ? '0 : rr_inc[PW-1:0];
          cnt_d       = CW'(READ_LATENCY - 1);
          state_d     = StGrant;
        end
      end
      StGrant: begin
        if (mem_we_q) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          rd_done = 1'b1;
        end else begin
          cnt_d   = cnt_q - CW'(1);
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        if (cnt_q == '0) rd_done = 1'b1;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = StIdle;
    endcase
    if (rd_done) begin
      rdata_d  = mem_rdata;
      rvalid_d = NUM_PORTS'(1) << owner_q;
      state_d  = StIdle;
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      rr_q        <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a transaction-timeline model of the arbiter and RAM.
module tb_unified_mem_arbiter;

  localparam int N  = 4;
  localparam int RL = 2;
  localparam int AW = 5;
  localparam int DW = 16;

  logic            clock;
  logic            reset;
  logic            boot_mode;
  logic [N-1:0]    req;
  logic [N-1:0]    we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic [DW-1:0]   rdata;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            busy;

  unified_mem_arbiter #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .NUM_PORTS   (N),
    .READ_LATENCY(RL)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .boot_mode(boot_mode),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM: write at the clock edge, read combinationally from the held mem_addr.
  bit [DW-1:0] ram [32];
  always @(posedge clock) if (mem_we) ram[mem_addr] <= mem_wdata;
  assign mem_rdata = ram[mem_addr];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Requestor state.
  logic [N-1:0]  pend_v;
  logic [N-1:0]  pend_we;
  logic [AW-1:0] pend_addr  [N];
  logic [DW-1:0] pend_wdata [N];
  int            mode [N];      // 0 none, 1 random, 2 always write
  logic          boot;
  logic          rand_boot;

  // Reference model: expected outputs on a timeline of cycle numbers.
  bit [DW-1:0]   mram [32];
  logic [N-1:0]  x_gnt;
  logic          x_we;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_wdata;
  logic [DW-1:0] x_rdata;
  int            rr, idle_at, rv_at, rv_port;
  logic [DW-1:0] rv_data;
  logic          prev_busy;

  int g_port[$], g_cyc[$], r_port[$], r_cyc[$], r_data[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int oh2idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic clear_logs();
    g_port.delete(); g_cyc.delete(); r_port.delete(); r_cyc.delete(); r_data.delete();
  endtask

  task automatic model_reset();
    x_gnt = '0; x_we = 1'b0; x_addr = '0; x_wdata = '0; x_rdata = '0;
    rr = 0; idle_at = 0; rv_at = -1; prev_busy = 1'b0; pend_v = '0;
  endtask

  task automatic set_pend(input int p, input logic w, input int a, input int d);
    pend_v[p]     = 1'b1;
    pend_we[p]    = w;
    pend_addr[p]  = AW'(a);
    pend_wdata[p] = DW'(d);
  endtask

  // Generate requests, drive the pins, and predict what the next cycle must show.
  task automatic plan_cycle();
    logic [N-1:0] elig;
    int w;
    if (rand_boot && $urandom_range(0, 29) == 0) boot = ~boot;
    for (int p = 0; p < N; p++) begin
      if (!pend_v[p]) begin
        if (mode[p] == 2) set_pend(p, 1'b1, $urandom_range(0, 31), $urandom);
        else if (mode[p] == 1 && $urandom_range(0, 2) == 0)
          set_pend(p, 1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom);
      end
    end
    boot_mode = boot;
    for (int p = 0; p < N; p++) begin
      req[p]             = pend_v[p];
      we[p]              = pend_we[p];
      addr[p*AW +: AW]   = pend_addr[p];
      wdata[p*DW +: DW]  = pend_wdata[p];
    end
    x_gnt = '0;
    x_we  = 1'b0;
    elig  = boot ? (pend_v & N'(1)) : pend_v;
    if (cyc >= idle_at && elig != '0) begin
      w = -1;
      for (int k = 0; k < N; k++) if (w < 0 && elig[(rr + k) % N]) w = (rr + k) % N;
      x_gnt   = N'(1) << w;
      x_we    = pend_we[w];
      x_addr  = pend_addr[w];
      x_wdata = pend_wdata[w];
      rr      = (w + 1) % N;
      if (pend_we[w]) begin
        mram[pend_addr[w]] = pend_wdata[w];
        idle_at = cyc + 2;
      end else begin
        rv_at   = cyc + 1 + RL;
        rv_port = w;
        rv_data = mram[pend_addr[w]];
        idle_at = rv_at;
      end
    end
  endtask

  task automatic tick();
    logic [N-1:0] xrv;
    @(posedge clock);
    #1;
    cyc++;
    xrv = (cyc == rv_at) ? (N'(1) << rv_port) : '0;
    if (cyc == rv_at) x_rdata = rv_data;
    check_eq("gnt", 32'(gnt), 32'(x_gnt));
    check_eq("rvalid", 32'(rvalid), 32'(xrv));
    check_eq("rdata", 32'(rdata), 32'(x_rdata));
    check_eq("mem_we", 32'(mem_we), 32'(x_we));
    check_eq("mem_addr", 32'(mem_addr), 32'(x_addr));
    check_eq("mem_wdata", 32'(mem_wdata), 32'(x_wdata));
    check_eq("busy", 32'(busy), 32'(cyc < idle_at));
    check_eq("gnt_while_busy", 32'(gnt != '0 && prev_busy), 32'd0);
    check_eq("gnt_rvalid_clash", 32'(gnt != '0 && rvalid != '0 && gnt != rvalid), 32'd0);
    prev_busy = busy;
    if (gnt != '0) begin g_port.push_back(oh2idx(gnt)); g_cyc.push_back(cyc); end
    if (rvalid != '0) begin
      r_port.push_back(oh2idx(rvalid)); r_cyc.push_back(cyc); r_data.push_back(int'(rdata));
    end
    for (int p = 0; p < N; p++) if (x_gnt[p]) pend_v[p] = 1'b0;
  endtask

  task automatic step();
    tick();
    plan_cycle();
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max; i++) begin
      if (pend_v == '0 && cyc >= idle_at) break;
      step();
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_gnt"}, 32'(gnt), 32'd0);
    check_eq({pfx, "_rvalid"}, 32'(rvalid), 32'd0);
    check_eq({pfx, "_rdata"}, 32'(rdata), 32'd0);
    check_eq({pfx, "_mem_we"}, 32'(mem_we), 32'd0);
    check_eq({pfx, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check_eq({pfx, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check_eq({pfx, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic injected;
    logic hit;
    reset = 1'b0; boot = 1'b0; rand_boot = 1'b0; boot_mode = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0;
    pend_we = '0;
    for (int p = 0; p < N; p++) begin mode[p] = 0; pend_addr[p] = '0; pend_wdata[p] = '0; end
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("rst");
    reset = 1'b1;

    // Boot load: only the loader may be granted.
    boot = 1'b1;
    set_pend(0, 1'b1, 3, 'hBEEF);
    set_pend(1, 1'b0, 3, 0);
    plan_cycle();
    repeat (8) step();
    check_eq("boot_grants", 32'(g_port.size()), 32'd1);
    check_eq("boot_port", 32'(q_at(g_port, 0)), 32'd0);

    // Boot released: port 1 read of the loaded word.
    clear_logs();
    tick();
    boot = 1'b0;
    plan_cycle();
    repeat (6) step();
    check_eq("rd_port", 32'(q_at(g_port, 0)), 32'd1);
    check_eq("rd_rvalid_port", 32'(q_at(r_port, 0)), 32'd1);
    check_eq("rd_latency", 32'(q_at(r_cyc, 0) - q_at(g_cyc, 0)), 32'(RL));
    check_eq("rd_data", 32'(q_at(r_data, 0)), 32'hBEEF);

    // Back-to-back: write then read of the same word, read presented in the gnt cycle.
    clear_logs();
    tick();
    set_pend(0, 1'b1, 9, 'h5A5A);
    plan_cycle();
    injected = 1'b0;
    for (int i = 0; i < 6 && !injected; i++) begin
      tick();
      if (!pend_v[0]) begin set_pend(0, 1'b0, 9, 0); injected = 1'b1; end
      plan_cycle();
    end
    repeat (6) step();
    check_eq("b2b_grants", 32'(g_port.size()), 32'd2);
    check_eq("b2b_gap", 32'(q_at(g_cyc, 1) - q_at(g_cyc, 0)), 32'd2);
    check_eq("b2b_data", 32'(q_at(r_data, 0)), 32'h5A5A);
    check_eq("b2b_rd_latency", 32'(q_at(r_cyc, 0) - q_at(g_cyc, 1)), 32'(RL));

    // Reset while port 1 sits in the read wait.
    clear_logs();
    tick();
    set_pend(1, 1'b0, 9, 0);
    plan_cycle();
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rv_at == cyc + 1) begin hit = 1'b1; break; end
      plan_cycle();
    end
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("rstmid");
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Fairness from rr_ptr=0 with every port writing continuously.
    clear_logs();
    for (int p = 0; p < N; p++) mode[p] = 2;
    plan_cycle();
    for (int i = 0; i < 40 && g_port.size() < 7; i++) begin
      tick();
      if (g_port.size() >= 7) for (int p = 0; p < N; p++) mode[p] = 0;
      plan_cycle();
    end
    for (int p = 0; p < N; p++) mode[p] = 0;
    check_eq("post_reset_no_rvalid", 32'(r_port.size()), 32'd0);
    for (int i = 0; i < 5; i++) check_eq("rr_order", 32'(q_at(g_port, i)), 32'(i % N));
    for (int i = 0; i < 4; i++)
      check_eq("rr_gap", 32'(q_at(g_cyc, i + 1) - q_at(g_cyc, i)), 32'd2);
    drain(30);

    // Wrap/skip: park rr_ptr at 3, then request ports 0 and 2.
    tick();
    set_pend(2, 1'b1, 1, 'h0002);
    plan_cycle();
    drain(20);
    clear_logs();
    tick();
    set_pend(0, 1'b1, 4, 'h1111);
    set_pend(2, 1'b1, 5, 'h2222);
    plan_cycle();
    drain(20);
    check_eq("wrap_grants", 32'(g_port.size()), 32'd2);
    check_eq("wrap_first", 32'(q_at(g_port, 0)), 32'd0);
    check_eq("wrap_second", 32'(q_at(g_port, 1)), 32'd2);

    // Random traffic with occasional boot_mode toggles.
    for (int p = 0; p < N; p++) mode[p] = 1;
    rand_boot = 1'b1;
    repeat (1500) step();
    for (int p = 0; p < N; p++) mode[p] = 0;
    rand_boot = 1'b0;
    boot = 1'b0;
    drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
